// File: rtl/rv32_bus_responder.sv
// rv32_bus_responder
//
// Single-cycle memory-mapped responder for an RV32 core. It holds a
// word-addressed on-chip RAM, an optional machine-timer window
// (mtime / mtimecmp / status) and a sticky bus-error flag for accesses that
// hit no mapped region.
//
// Address map:
//   [0, RAM_WORDS*4)            RAM, asynchronous read, byte-masked write
//   TIMER_BASE + 0x00..0x1F     timer window (only with the macro below)
//   everything else             unmapped: reads 0, sets bus_error_out
//
// Timer window word offsets:
//   0x00 mtime[31:0]    0x04 mtime[63:32]
//   0x08 mtimecmp[31:0] 0x0C mtimecmp[63:32]
//   0x10 status = {30'b0, bus_error_out, timer_irq_out}; writing bit 1 with
//        mask[0] set clears bus_error_out
//   0x14..0x1C read 0, writes ignored
//
// Build option:
//   RV32_BUS_RESPONDER_TIMER_EN  defined   -> timer window present
//                                undefined -> no timer logic; the timer window
//                                decodes as unmapped, timer_irq_out is 0 and
//                                bus_error_out clears only on reset
//
// Ports:
//   clk             in   clock, all state changes on the rising edge
//   reset           in   asynchronous active-high reset
//   read_in         in   read request at address_in this cycle
//   write_mask_in   in   per-byte write enables, nonzero = write request
//   address_in      in   byte address, bits [1:0] ignored
//   write_value_in  in   write data, byte-lane aligned
//   read_value_out  out  combinational read data, 0 when read_in is low
//   timer_irq_out   out  registered (mtime >= mtimecmp)
//   bus_error_out   out  sticky unmapped-access flag

module rv32_bus_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [31:0] TIMER_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] address_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        timer_irq_out,
    output logic        bus_error_out
);

    localparam int unsigned AddrW    = $clog2(RAM_WORDS);
    localparam logic [31:0] RamBytes = 32'(RAM_WORDS * 4);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic             write_req;
    logic             access_req;
    logic             sel_ram;
    logic             sel_timer;
    logic             sel_unmapped;
    logic [AddrW-1:0] ram_idx;
    logic [31:0]      lane_mask;
    logic             unused_addr_lsbs;

    assign write_req    = |write_mask_in;
    assign access_req   = read_in | write_req;
    assign ram_idx      = address_in[AddrW+1:2];
    assign lane_mask    = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                           {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
    assign sel_ram      = address_in < RamBytes;
    assign sel_unmapped = !sel_ram && !sel_timer;

    // Accesses are word-wide; the byte offset carries no information.
    assign unused_addr_lsbs = ^address_in[1:0];

    // ------------------------------------------------------------------
    // RAM: not reset, written only when reset is low
    // ------------------------------------------------------------------
    logic [31:0] ram_q [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (!reset && sel_ram && write_req) begin
            ram_q[ram_idx] <= (ram_q[ram_idx] & ~lane_mask) | (write_value_in & lane_mask);
        end
    end

    // ------------------------------------------------------------------
    // Timer window
    // ------------------------------------------------------------------
    logic [31:0] timer_rdata;
    logic        status_clr;

`ifdef RV32_BUS_RESPONDER_TIMER_EN
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        timer_irq_q, timer_irq_d;
    logic [2:0]  timer_off;
    logic        timer_wr;

    assign sel_timer = !sel_ram && (address_in[31:5] == TIMER_BASE[31:5]);
    assign timer_off = address_in[4:2];
    assign timer_wr  = sel_timer && write_req;

    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        status_clr = 1'b0;
        if (timer_wr) begin
            case (timer_off)
                // A write to either mtime half replaces this cycle's increment;
                // unmasked lanes keep the un-incremented value.
                3'd0: mtime_d = {mtime_q[63:32],
                                 (mtime_q[31:0] & ~lane_mask) | (write_value_in & lane_mask)};
                3'd1: mtime_d = {(mtime_q[63:32] & ~lane_mask) | (write_value_in & lane_mask),
                                 mtime_q[31:0]};
                3'd2: mtimecmp_d[31:0]  = (mtimecmp_q[31:0] & ~lane_mask)
                                          | (write_value_in & lane_mask);
                3'd3: mtimecmp_d[63:32] = (mtimecmp_q[63:32] & ~lane_mask)
                                          | (write_value_in & lane_mask);
                3'd4: status_clr = write_mask_in[0] && write_value_in[1];
                default: ;
            endcase
        end
        // Compare against the values being loaded so the irq tracks the edge.
        timer_irq_d = mtime_d >= mtimecmp_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            timer_irq_q <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    always_comb begin
        timer_rdata = 32'd0;
        case (timer_off)
            3'd0:    timer_rdata = mtime_q[31:0];
            3'd1:    timer_rdata = mtime_q[63:32];
            3'd2:    timer_rdata = mtimecmp_q[31:0];
            3'd3:    timer_rdata = mtimecmp_q[63:32];
            3'd4:    timer_rdata = {30'd0, bus_error_out, timer_irq_q};
            default: timer_rdata = 32'd0;
        endcase
    end

    assign timer_irq_out = timer_irq_q;
`else
    logic unused_timer_base;

    assign sel_timer         = 1'b0;
    assign timer_rdata       = 32'd0;
    assign status_clr        = 1'b0;
    assign timer_irq_out     = 1'b0;
    assign unused_timer_base = ^TIMER_BASE;
`endif

    // ------------------------------------------------------------------
    // Sticky bus error: a new unmapped access wins over a status clear
    // ------------------------------------------------------------------
    logic bus_error_q, bus_error_d;

    always_comb begin
        bus_error_d = bus_error_q;
        if (status_clr) begin
            bus_error_d = 1'b0;
        end
        if (sel_unmapped && access_req) begin
            bus_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_error_q <= 1'b0;
        end else begin
            bus_error_q <= bus_error_d;
        end
    end

    assign bus_error_out = bus_error_q;

    // ------------------------------------------------------------------
    // Read mux: pre-edge contents, so a same-cycle write returns old data
    // ------------------------------------------------------------------
    always_comb begin
        read_value_out = 32'd0;
        if (read_in) begin
            if (sel_ram) begin
                read_value_out = ram_q[ram_idx];
            end else if (sel_timer) begin
                read_value_out = timer_rdata;
            end
        end
    end

endmodule
